// File: rtl/fp32_stb_multiplier.sv
// rtl/fp32_stb_multiplier.sv - binary32 multiplier behind stb/ack operand and result handshakes
module fp32_stb_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] input_a,
   input  logic             input_a_stb,
   output logic             input_a_ack,
   input  logic [WIDTH-1:0] input_b,
   input  logic             input_b_stb,
   output logic             input_b_ack,
   output logic [WIDTH-1:0] output_z,
   output logic             output_z_stb,
   input  logic             output_z_ack
);

   typedef enum logic [3:0] {
      GET_A, GET_B, UNPACK, SPECIAL, MULT, NORM, ROUND, PACK, PUT_Z
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_reg, b_reg, z;
   logic             a_s, b_s, z_s;
   logic [7:0]       a_e, b_e;
   logic [23:0]      a_m, b_m, z_m;
   logic [47:0]      prod;
   logic signed [9:0] z_e;
   logic             guard, round_bit, sticky;

   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_hit;
   logic [31:0]      special_z;
   logic             carry;
   logic [23:0]      m_inc;

   always_comb begin
      // Subnormals were flushed at unpack, so exponent zero means zero here.
      a_nan  = (a_e == 8'hff) && (a_m[22:0] != 23'd0);
      b_nan  = (b_e == 8'hff) && (b_m[22:0] != 23'd0);
      a_inf  = (a_e == 8'hff) && (a_m[22:0] == 23'd0);
      b_inf  = (b_e == 8'hff) && (b_m[22:0] == 23'd0);
      a_zero = (a_e == 8'h00);
      b_zero = (b_e == 8'h00);
      special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
      special_z = {a_s ^ b_s, 31'd0};
      if (a_nan || b_nan)
         special_z = 32'h7fc00000;
      else if ((a_inf && b_zero) || (b_inf && a_zero))
         special_z = 32'h7fc00000;
      else if (a_inf || b_inf)
         special_z = {a_s ^ b_s, 8'hff, 23'd0};
      {carry, m_inc} = {1'b0, z_m} + 25'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         GET_A:   if (input_a_stb) state_nxt = GET_B;
         GET_B:   if (input_b_stb) state_nxt = UNPACK;
         UNPACK:  state_nxt = SPECIAL;
         SPECIAL: state_nxt = special_hit ? PUT_Z : MULT;
         MULT:    state_nxt = NORM;
         NORM:    state_nxt = ROUND;
         ROUND:   state_nxt = PACK;
         PACK:    state_nxt = PUT_Z;
         PUT_Z:   if (output_z_ack) state_nxt = GET_A;
         default: state_nxt = GET_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= GET_A;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z <= '0;
      end else begin
         case (state)
            GET_A: if (input_a_stb) a_reg <= input_a;
            GET_B: if (input_b_stb) b_reg <= input_b;
            UNPACK: begin
               a_s <= a_reg[31];
               b_s <= b_reg[31];
               a_e <= a_reg[30:23];
               b_e <= b_reg[30:23];
               a_m <= (a_reg[30:23] != 8'd0) ? {1'b1, a_reg[22:0]} : 24'd0;
               b_m <= (b_reg[30:23] != 8'd0) ? {1'b1, b_reg[22:0]} : 24'd0;
            end
            SPECIAL: begin
               z_s <= a_s ^ b_s;
               if (special_hit) z <= special_z;
            end
            MULT: begin
               prod <= {24'd0, a_m} * {24'd0, b_m};
               z_e  <= $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - 10'sd127;
            end
            NORM: begin
               if (prod[47]) begin
                  z_m       <= prod[47:24];
                  guard     <= prod[23];
                  round_bit <= prod[22];
                  sticky    <= |prod[21:0];
                  z_e       <= z_e + 10'sd1;
               end else begin
                  z_m       <= prod[46:23];
                  guard     <= prod[22];
                  round_bit <= prod[21];
                  sticky    <= |prod[20:0];
               end
            end
            ROUND: begin
               if (guard && (round_bit || sticky || z_m[0])) begin
                  if (carry) begin
                     z_m <= 24'h800000;
                     z_e <= z_e + 10'sd1;
                  end else begin
                     z_m <= m_inc;
                  end
               end
            end
            PACK: begin
               if (z_e >= 10'sd255)
                  z <= {z_s, 8'hff, 23'd0};
               else if (z_e <= 10'sd0)
                  z <= {z_s, 31'd0};
               else
                  z <= {z_s, z_e[7:0], z_m[22:0]};
            end
            default: ;
         endcase
      end
   end

   assign input_a_ack  = (state == GET_A);
   assign input_b_ack  = (state == GET_B);
   assign output_z_stb = (state == PUT_Z);
   assign output_z     = z;

endmodule

// File: tb/tb_fp32_stb_multiplier.sv
// tb/tb_fp32_stb_multiplier.sv - randomized and directed bench for fp32_stb_multiplier
module tb_fp32_stb_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a, input_b, output_z;
   logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
   logic        output_z_stb, output_z_ack;

   int n_checks = 0;
   int n_err    = 0;
   int n_ops    = 0;
   int n_accept = 0;

   always #5 clk = ~clk;

   fp32_stb_multiplier #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
      .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
      .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
   );

   always @(posedge clk) if (!rst && output_z_stb && output_z_ack) n_accept++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
      return (a[30:23] == 8'h00) || (a[30:23] == 8'hff) ||
             (b[30:23] == 8'h00) || (b[30:23] == 8'hff);
   endfunction

   // Exact integer product, then round-to-nearest-even by comparing the
   // discarded remainder against one half of the kept LSB.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, sh;
      longint unsigned ma, mb, p, kept, rem, half;
      bit an, bn, ai, bi, az, bz;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      az = (ea == 0);
      bz = (eb == 0);
      if (an || bn) return 32'h7fc00000;
      if ((ai && bz) || (bi && az)) return 32'h7fc00000;
      if (ai || bi) return {s, 8'hff, 23'd0};
      if (az || bz) return {s, 31'd0};
      ma   = 64'h800000 + 64'(a[22:0]);
      mb   = 64'h800000 + 64'(b[22:0]);
      p    = ma * mb;
      sh   = (p >= (64'd1 << 47)) ? 24 : 23;
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept++;
      e = ea + eb - 127 + (sh - 23);
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hff, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], kept[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      int sel;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) r[30:23] = 8'h00;
      else if (sel == 1) r[30:23] = 8'hff;
      else if (sel > 3) r[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 5) == 0) r[22:0] = 23'd0;
      return r;
   endfunction

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_z_stb", output_z_stb, 0);
      chk("rst_z", output_z, 0);
      chk("rst_a_ack", input_a_ack, 1);
      chk("rst_b_ack", input_b_ack, 0);
   endtask

   // Hands A then B over and returns just after the B capture edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                           input bit cont, input bit b_first);
      int cnt;
      input_a      = a;
      input_b      = b;
      input_a_stb  = 1'b0;
      input_b_stb  = b_first;
      output_z_ack = cont;
      if (b_first) begin
         repeat (3) begin
            @(posedge clk); #1;
            chk("b_early_ignored", input_b_ack, 0);
         end
      end
      input_a_stb = 1'b1;
      if (cont) input_b_stb = 1'b1;
      cnt = 0;
      while (!input_a_ack && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("a_ack_seen", input_a_ack, 1);
      @(posedge clk); #1;
      if (!cont) input_a_stb = 1'b0;
      chk("a_ack_drop", input_a_ack, 0);
      input_b_stb = 1'b1;
      cnt = 0;
      while (!input_b_ack && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("b_ack_seen", input_b_ack, 1);
      @(posedge clk); #1;
      if (!cont) input_b_stb = 1'b0;
      chk("b_ack_drop", input_b_ack, 0);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_z,
                         input bit cont, input int hold, input bit b_first);
      int cnt;
      logic [31:0] z0;
      start_op(a, b, cont, b_first);
      cnt = 0;
      while (!output_z_stb && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("latency", cnt, is_special(a, b) ? 2 : 6);
      chk("result", output_z, exp_z);
      if (cont) begin
         @(posedge clk); #1;
         chk("stb_one_cycle", output_z_stb, 0);
      end else begin
         z0 = output_z;
         repeat (hold) begin
            @(posedge clk); #1;
            chk("stb_held", output_z_stb, 1);
            chk("z_stable", output_z, z0);
         end
         output_z_ack = 1'b1;
         @(posedge clk); #1;
         output_z_ack = 1'b0;
         chk("stb_drop", output_z_stb, 0);
      end
      n_ops++;
   endtask

   initial begin
      logic [31:0] ra, rb;
      int cnt;
      rst = 1'b1;
      input_a = '0; input_b = '0;
      input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_z_stb", output_z_stb, 0);
      chk("reset_z", output_z, 0);
      chk("reset_a_ack", input_a_ack, 1);
      chk("reset_b_ack", input_b_ack, 0);

      run_op(32'h40000000, 32'h40400000, 32'h40c00000, 1'b1, 0, 1'b0);
      run_op(32'hc0000000, 32'h40400000, 32'hc0c00000, 1'b1, 0, 1'b0);
      run_op(32'h3fc00000, 32'h3fc00000, 32'h40100000, 1'b0, 1, 1'b0);
      run_op(32'h3f800001, 32'h3f800001, 32'h3f800002, 1'b0, 0, 1'b0);
      run_op(32'h3f800003, 32'h3f800001, 32'h3f800004, 1'b0, 2, 1'b0);
      run_op(32'h7f800000, 32'h00000000, 32'h7fc00000, 1'b0, 0, 1'b0);
      run_op(32'h7fc00001, 32'h3f800000, 32'h7fc00000, 1'b1, 0, 1'b0);
      run_op(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 0, 1'b0);
      run_op(32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 0, 1'b0);
      run_op(32'h7f800000, 32'hc0000000, 32'hff800000, 1'b0, 0, 1'b0);
      run_op(32'h7f000000, 32'h7f000000, 32'h7f800000, 1'b0, 0, 1'b0);
      run_op(32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 0, 1'b0);
      run_op(32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 0, 1'b1);
      run_op(32'h3fc00000, 32'hc0000000, 32'hc0400000, 1'b0, 10, 1'b0);

      // Reset while in MULT: two edges past the B capture.
      start_op(32'h3fc00000, 32'h40000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      pulse_reset();
      run_op(32'h40000000, 32'h40400000, 32'h40c00000, 1'b0, 0, 1'b0);

      // Reset while the result is waiting in PUT_Z.
      start_op(32'h40800000, 32'h40800000, 1'b0, 1'b0);
      cnt = 0;
      while (!output_z_stb && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("putz_reached", output_z_stb, 1);
      pulse_reset();
      run_op(32'h40000000, 32'h40400000, 32'h40c00000, 1'b0, 0, 1'b0);

      for (int i = 0; i < 80; i++) begin
         ra = rand_op();
         rb = rand_op();
         run_op(ra, rb, ref_mul(ra, rb), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      end

      input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("accept_count", n_accept, n_ops);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fp32_stb_multiplier.md
# fp32_stb_multiplier

Single-precision (IEEE-754 binary32) multiplier that sits on the responder side of the team's stb/ack operand handshake. It accepts operand A, then operand B, each on its own strobe/acknowledge pair. It computes the product over a fixed multi-cycle datapath and presents the result on a strobe that is held until it is acknowledged. It is the drop-in multiplier unit instantiated by the column-level matrix engines in the coprocessor.

## Interface

- `WIDTH`, 32: operand and result width. Fixed at 32; other values are unsupported.
- `clk` in 1: clock. All logic updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `input_a` in 32: operand A.
- `input_a_stb` in 1: operand A valid.
- `input_a_ack` out 1: operand A accepted; high only in GET_A.
- `input_b` in 32: operand B.
- `input_b_stb` in 1: operand B valid.
- `input_b_ack` out 1: operand B accepted; high only in GET_B.
- `output_z` out 32: product.
- `output_z_stb` out 1: product valid; high only in PUT_Z.
- `output_z_ack` in 1: consumer has taken the product.

## Operation

- **States:** GET_A, GET_B, UNPACK, SPECIAL, MULT, NORM, ROUND, PACK, PUT_Z. Every state lasts one cycle except where a handshake waits.
- **GET_A:**
  - `input_a_ack`=1.
  - On an edge where `input_a_stb` && `input_a_ack`, capture `input_a` and go to GET_B.
- **GET_B:** same as GET_A, using B.
- **UNPACK:**
  - Split each operand into sign, 8-bit exponent and 24-bit significand.
  - The hidden bit is 1 when the exponent is nonzero.
  - Subnormal inputs (exp=0, frac≠0) are flushed to signed zero.
- **SPECIAL:** result sign is sA^sB. Checks are applied in this order:
  - Either operand NaN -> 0x7FC00000.
  - Inf × zero -> 0x7FC00000.
  - Either operand Inf -> signed Inf.
  - Either operand zero -> signed zero.
  - Any special case goes directly to PUT_Z. Otherwise go to MULT.
- **MULT:**
  - 48-bit product of the significands.
  - 10-bit signed exponent = eA + eB − 127.
- **NORM:**
  - If product bit 47 = 1, take bits 47:24, guard = 23, round = 22, sticky = OR(21:0), and exponent +1.
  - Otherwise take bits 46:23, guard = 22, round = 21, sticky = OR(20:0).
- **ROUND:**
  - Round to nearest, ties to even: increment when guard && (round || sticky || lsb).
  - If the increment carries out of the significand, shift right by 1 and exponent +1.
- **PACK:**
  - Exponent ≥ 255 -> signed Inf.
  - Exponent ≤ 0 -> signed zero (flush to zero, no subnormal outputs).
  - Otherwise {sign, exp[7:0], significand[22:0]}.
- **PUT_Z:**
  - `output_z_stb`=1 and `output_z` held stable.
  - On an edge with `output_z_ack`=1, go to GET_A. `output_z_stb` drops the next cycle.
- **No exception flags.** Only the canonical quiet NaN 0x7FC00000 is produced, and NaN payloads are not propagated.

## Timing

- **Reset:**
  - `rst`=1 at an edge forces GET_A.
  - Outputs after that edge: `input_a_ack`=1, `input_b_ack`=0, `output_z_stb`=0, `output_z`=0.
  - This takes effect from any state, including mid-computation and PUT_Z. The pending result is discarded.
- **Acknowledge timing:** acks are registered state decodes. Each ack falls on the cycle after its capture edge, so exactly one word is accepted per handshake.
- **Holding strobes:** a stb held high across several cycles is consumed once. After the capture, the block ignores it until it returns to that GET state.
- **Latency, normal path:** `output_z_stb` rises 6 edges after the B capture edge (UNPACK, SPECIAL, MULT, NORM, ROUND, PACK).
- **Latency, special path:** `output_z_stb` rises 2 edges after the B capture edge.
- **Throughput:** one result per (2 + 6 + 1) cycles minimum when all stbs and acks are asserted continuously.
- **Ordering:** A must be accepted before B. While the block is in GET_A, `input_b_stb` is ignored.
- **Back-pressure:** `output_z_ack` may be held low indefinitely. `output_z` must not change while `output_z_stb`=1.
- **Ack asserted early:** an `output_z_ack` already high when PUT_Z is entered completes the handshake on the first PUT_Z edge. The strobe is then high for exactly one cycle.

## Test plan

- **Basic products, continuous handshakes:** stbs and acks held high.
  - 0x40000000 × 0x40400000 -> 0x40C00000.
  - 0xC0000000 × 0x40400000 -> 0xC0C00000.
  - `output_z_stb` rises 6 edges after the B capture.
- **Normalisation and rounding:**
  - 0x3FC00000 × 0x3FC00000 -> 0x40100000 (exercises the bit-47 shift).
  - 0x3F800001 × 0x3F800001 -> 0x3F800002 (round down).
  - 0x3F800003 × 0x3F800001 -> 0x3F800004 (sticky).
- **Special cases:**
  - 0x7F800000 × 0x00000000 -> 0x7FC00000.
  - 0x7FC00001 × 0x3F800000 -> 0x7FC00000.
  - 0x80000000 × 0x40000000 -> 0x80000000.
  - 0x00000001 × 0x40000000 -> 0x00000000.
  - `output_z_stb` rises 2 edges after the B capture in every special case.
- **Range limits:**
  - 0x7F000000 × 0x7F000000 -> 0x7F800000.
  - 0x00800000 × 0x00800000 -> 0x00000000.
- **Handshake:**
  - Assert `input_b_stb` before `input_a_stb` -> B is not accepted until A is.
  - Hold `output_z_ack` low 10 cycles -> `output_z_stb` stays 1 and `output_z` is constant throughout.
  - Back-to-back operations give each result exactly once.
- **Reset mid-operation:** pulse `rst` in MULT and again in PUT_Z. After each pulse:
  - `output_z_stb`=0, `output_z`=0, `input_a_ack`=1.
  - The next operation, 0x40000000 × 0x40400000, gives 0x40C00000.
